// File: rtl/clic_timer_src_pkg.sv
// Shared definitions for the CLIC timer source: register map, CTRL layout
// and helpers that pack/unpack the CTRL register.
package clic_timer_src_pkg;

   localparam int CsrWidth   = 32;
   localparam int PsWidth    = 4;
   localparam int PrescWidth = 16;

   localparam logic [1:0] TimerCtrlAddr   = 2'd0;
   localparam logic [1:0] TimerCmpAddr    = 2'd1;
   localparam logic [1:0] TimerCntAddr    = 2'd2;
   localparam logic [1:0] TimerStatusAddr = 2'd3;

   localparam int CtrlEnBit   = 0;
   localparam int CtrlModeBit = 1;
   localparam int CtrlPsLsb   = 4;
   localparam int CtrlPsMsb   = 7;

   localparam int StatusPendBit = 0;
   localparam int StatusOvrLsb  = 8;

   typedef struct packed {
      logic [PsWidth-1:0] ps;
      logic               mode;
      logic               en;
   } timer_ctrl_t;

   function automatic timer_ctrl_t ctrl_from_wdata(input logic [CsrWidth-1:0] wdata);
      timer_ctrl_t c;
      c.ps   = wdata[CtrlPsMsb:CtrlPsLsb];
      c.mode = wdata[CtrlModeBit];
      c.en   = wdata[CtrlEnBit];
      return c;
   endfunction

   // Unused CTRL bits always read back as zero.
   function automatic logic [CsrWidth-1:0] ctrl_to_rdata(input timer_ctrl_t c);
      logic [CsrWidth-1:0] r;
      r                      = '0;
      r[CtrlPsMsb:CtrlPsLsb] = c.ps;
      r[CtrlModeBit]         = c.mode;
      r[CtrlEnBit]           = c.en;
      return r;
   endfunction

endpackage

// File: rtl/clic_timer_src_prescaler.sv
// Power-of-two prescaler: free-running counter that ticks whenever its low
// ps bits are all ones, i.e. once every 2^ps enabled cycles.
module clic_timer_src_prescaler
   import clic_timer_src_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic               clear,
   input  logic [PsWidth-1:0] ps,
   output logic               tick
);

   logic [PrescWidth-1:0] r_cnt;
   logic [PrescWidth-1:0] w_mask;

   assign w_mask = (PrescWidth'(1) << ps) - PrescWidth'(1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (!en || clear) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + PrescWidth'(1);
      end
   end

   // A register write in the same cycle suppresses the tick so the write wins.
   assign tick = en && !clear && ((r_cnt & w_mask) == w_mask);

endmodule

// File: rtl/clic_timer_src.sv
// Memory-mapped compare-match timer driving one CLIC request line; periodic or
// one-shot, prescaled, with saturating overrun accounting on unacknowledged expiries.
module clic_timer_src
   import clic_timer_src_pkg::*;
#(
   parameter int CntWidth = 32,
   parameter int OvrWidth = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                csr_we,
   input  logic [1:0]          csr_addr,
   input  logic [CsrWidth-1:0] csr_wdata,
   output logic [CsrWidth-1:0] csr_rdata,
   input  logic                irq_ack,
   output logic                irq_req,
   output logic                expired
);

   localparam logic [OvrWidth-1:0] OvrMax = '1;

   timer_ctrl_t         r_ctrl;
   timer_ctrl_t         w_ctrl_wr;
   logic [CntWidth-1:0] r_cmp;
   logic [CntWidth-1:0] r_cnt;
   logic [CntWidth-1:0] w_cnt_nxt;
   logic [OvrWidth-1:0] r_ovr;
   logic                r_pending;
   logic                r_expired;

   logic w_ctrl_we;
   logic w_cmp_we;
   logic w_status_we;
   logic w_presc_clear;
   logic w_tick;
   logic w_match;
   logic w_expiry;
   logic w_en_rise;
   logic w_pend_clr;
   logic w_unused_wdata;

   assign w_ctrl_we   = csr_we && (csr_addr == TimerCtrlAddr);
   assign w_cmp_we    = csr_we && (csr_addr == TimerCmpAddr);
   assign w_status_we = csr_we && (csr_addr == TimerStatusAddr);
   assign w_ctrl_wr   = ctrl_from_wdata(csr_wdata);

   assign w_presc_clear = w_ctrl_we || w_cmp_we;

   clic_timer_src_prescaler u_prescaler (
      .clk   (clk),
      .reset (reset),
      .en    (r_ctrl.en),
      .clear (w_presc_clear),
      .ps    (r_ctrl.ps),
      .tick  (w_tick)
   );

   assign w_match    = (r_cnt == r_cmp);
   assign w_expiry   = w_tick && w_match;
   assign w_en_rise  = w_ctrl_we && w_ctrl_wr.en && !r_ctrl.en;
   assign w_pend_clr = irq_ack || (w_status_we && csr_wdata[StatusPendBit]);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ctrl <= '0;
      end else if (w_ctrl_we) begin
         r_ctrl <= w_ctrl_wr;
      end else if (w_expiry && !r_ctrl.mode) begin
         r_ctrl.en <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cmp <= '0;
      end else if (w_cmp_we) begin
         r_cmp <= csr_wdata[CntWidth-1:0];
      end
   end

   // CNT can never run past CMP because every CMP write restarts it from zero.
   always_comb begin
      w_cnt_nxt = r_cnt;
      if (w_cmp_we || w_en_rise) begin
         w_cnt_nxt = '0;
      end else if (w_tick) begin
         w_cnt_nxt = w_match ? '0 : r_cnt + CntWidth'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_nxt;
      end
   end

   // A fresh expiry outranks any clear arriving in the same cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pending <= 1'b0;
      end else if (w_expiry) begin
         r_pending <= 1'b1;
      end else if (w_pend_clr) begin
         r_pending <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ovr <= '0;
      end else if (w_status_we) begin
         r_ovr <= '0;
      end else if (w_expiry && r_pending && !irq_ack && (r_ovr != OvrMax)) begin
         r_ovr <= r_ovr + OvrWidth'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_expired <= 1'b0;
      end else begin
         r_expired <= w_expiry;
      end
   end

   assign irq_req = r_pending;
   assign expired = r_expired;

   always_comb begin
      csr_rdata = '0;
      case (csr_addr)
         TimerCtrlAddr: csr_rdata = ctrl_to_rdata(r_ctrl);
         TimerCmpAddr:  csr_rdata[CntWidth-1:0] = r_cmp;
         TimerCntAddr:  csr_rdata[CntWidth-1:0] = r_cnt;
         default: begin
            csr_rdata[StatusPendBit]           = r_pending;
            csr_rdata[StatusOvrLsb +: OvrWidth] = r_ovr;
         end
      endcase
   end

   // Only some write-data bits are meaningful for each register.
   assign w_unused_wdata = ^csr_wdata;

endmodule
